// File: rtl/calc_pkg.sv
// Shared types for the execute stage.
//   op_t    : 3-bit operation encoding seen on exec_unit.op
//   state_t : execute FSM states
//   mode_t  : iterative engine mode (multiply or divide)
//   FLAG_*  : bit positions inside the 3-bit flags word {div0, ovf, zero}
package calc_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_MUL  = 3'b100,
        OP_DIVQ = 3'b101,
        OP_DIVR = 3'b110,
        OP_RSVD = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        WB   = 2'd3
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_t;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_DIV0 = 2;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply / unsigned restoring divide engine, one bit per step.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   load          capture operands and clear the step counter
//   mode          MODE_MUL or MODE_DIV, sampled with load and on every step
//   step          perform one iteration
//   op_a, op_b    multiplicand/multiplier or dividend/divisor (sampled on load)
//   lo, hi        accumulator halves AFTER the current step (product low/high,
//                 or quotient/remainder), so the caller can write back on the
//                 same edge as the final step
//   last          high during the final (WIDTH-th) step
module muldiv_iter
    import calc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  mode_t            mode,
    input  logic             step,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             last
);

    localparam int CNT_W = $clog2(WIDTH);

    // Multiply: acc = {partial product, remaining multiplier bits}, shifts right.
    // Divide:   acc = {partial remainder, remaining dividend / quotient bits}, shifts left.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   m_q, m_d;       // multiplicand or divisor
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_trial;
    logic [WIDTH:0] div_sub;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        acc_d = acc_q;
        m_d   = m_q;
        cnt_d = cnt_q;

        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
        // Trial remainder is at most 2*divisor-1, so WIDTH+1 bits suffice; a set
        // MSB on the subtraction means trial < divisor (restore).
        div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_sub   = div_trial - {1'b0, m_q};

        if (load) begin
            cnt_d = '0;
            if (mode == MODE_MUL) begin
                acc_d = {{WIDTH{1'b0}}, op_b};
                m_d   = op_a;
            end else begin
                acc_d = {{WIDTH{1'b0}}, op_a};
                m_d   = op_b;
            end
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
            if (mode == MODE_MUL) begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end else if (!div_sub[WIDTH]) begin
                acc_d = {div_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) begin
            acc_q <= '0;
            m_q   <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            m_q   <= m_d;
            cnt_q <= cnt_d;
        end
    end

    assign lo   = acc_d[WIDTH-1:0];
    assign hi   = acc_d[2*WIDTH-1:WIDTH];
    assign last = step && (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU plus iterative MUL / unsigned DIVQ / DIVR,
// with one registered write-back cycle per accepted op.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, op, dir_dst       request, operation, destination (sampled in IDLE)
//   datA, datB               operands, read only in the accept cycle
//   busy                     state != IDLE
//   done                     one-cycle pulse, same cycle as reg_write
//   reg_write, dir_WR,       registered register-file write port, valid
//   data_in                  for exactly the WB cycle, held afterwards
//   flags                    {div0, ovf, zero} of the last write-back
module exec_unit
    import calc_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] dir_dst,
    input  logic [WIDTH-1:0]  datA,
    input  logic [WIDTH-1:0]  datB,
    output logic              busy,
    output logic              done,
    output logic              reg_write,
    output logic [ADDR_W-1:0] dir_WR,
    output logic [WIDTH-1:0]  data_in,
    output logic [2:0]        flags
);

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [ADDR_W-1:0]  dst_q, dst_d;
    logic               reg_write_q, reg_write_d;
    logic [ADDR_W-1:0]  dir_wr_q, dir_wr_d;
    logic [WIDTH-1:0]   data_in_q, data_in_d;
    logic [2:0]         flags_q, flags_d;

    op_t                op_in;
    logic               is_div, b_zero;
    logic [WIDTH-1:0]   sum, diff, res;
    logic               ovf_r, div0_r;

    logic               md_load, md_step, md_last;
    mode_t              md_mode;
    logic [WIDTH-1:0]   md_lo, md_hi;

    assign op_in  = op_t'(op);
    assign is_div = (op_in == OP_DIVQ) || (op_in == OP_DIVR);
    assign b_zero = (datB == '0);
    assign sum    = datA + datB;
    assign diff   = datA - datB;

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk  (clk),
        .rst  (rst),
        .load (md_load),
        .mode (md_mode),
        .step (md_step),
        .op_a (datA),
        .op_b (datB),
        .lo   (md_lo),
        .hi   (md_hi),
        .last (md_last)
    );

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            dst_q       <= '0;
            reg_write_q <= 1'b0;
            dir_wr_q    <= '0;
            data_in_q   <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            dst_q       <= dst_d;
            reg_write_q <= reg_write_d;
            dir_wr_q    <= dir_wr_d;
            data_in_q   <= data_in_d;
            flags_q     <= flags_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op_in == OP_MUL)         state_d = MUL;
                    else if (is_div && !b_zero)  state_d = DIV;
                    else                         state_d = WB;
                end
            end
            MUL, DIV: if (md_last) state_d = WB;
            WB:       state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output / datapath logic: the write-back registers load on the edge that enters WB.
    always_comb begin
        op_d        = op_q;
        dst_d       = dst_q;
        reg_write_d = 1'b0;
        dir_wr_d    = dir_wr_q;
        data_in_d   = data_in_q;
        flags_d     = flags_q;
        md_load     = 1'b0;
        md_mode     = (state_q == DIV) ? MODE_DIV : MODE_MUL;
        md_step     = (state_q == MUL) || (state_q == DIV);
        res         = '0;
        ovf_r       = 1'b0;
        div0_r      = 1'b0;

        if (state_q == IDLE && start) begin
            op_d    = op_in;
            dst_d   = dir_dst;
            md_mode = is_div ? MODE_DIV : MODE_MUL;
            md_load = (op_in == OP_MUL) || (is_div && !b_zero);
        end

        case (state_q)
            IDLE: begin
                case (op_in)
                    OP_ADD: begin
                        res   = sum;
                        ovf_r = (datA[WIDTH-1] == datB[WIDTH-1]) && (sum[WIDTH-1] != datA[WIDTH-1]);
                    end
                    OP_SUB: begin
                        res   = diff;
                        ovf_r = (datA[WIDTH-1] != datB[WIDTH-1]) && (diff[WIDTH-1] != datA[WIDTH-1]);
                    end
                    OP_AND:  res = datA & datB;
                    OP_OR:   res = datA | datB;
                    // Only reach WB from IDLE with a divide when the divisor is zero.
                    OP_DIVQ: begin res = '1;   div0_r = 1'b1; end
                    OP_DIVR: begin res = datA; div0_r = 1'b1; end
                    default: res = '0;
                endcase
            end
            MUL: begin
                res   = md_lo;
                ovf_r = |md_hi;
            end
            DIV:     res = (op_q == OP_DIVR) ? md_hi : md_lo;
            default: res = '0;
        endcase

        if (state_d == WB) begin
            reg_write_d        = 1'b1;
            data_in_d          = res;
            dir_wr_d           = (state_q == IDLE) ? dir_dst : dst_q;
            flags_d[FLAG_DIV0] = div0_r;
            flags_d[FLAG_OVF]  = ovf_r;
            flags_d[FLAG_ZERO] = (res == '0);
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = reg_write_q;
    assign reg_write = reg_write_q;
    assign dir_WR    = dir_wr_q;
    assign data_in   = data_in_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: reset, directed vector table, start-hold
// sequence during a divide, and random ops against a behavioural model.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [3:0]  dir_dst;
    logic [31:0] datA, datB;
    logic        busy, done, reg_write;
    logic [3:0]  dir_WR;
    logic [31:0] data_in;
    logic [2:0]  flags;

    int total = 0;
    int bad   = 0;

    exec_unit #(.WIDTH(32), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .dir_dst   (dir_dst),
        .datA      (datA),
        .datB      (datB),
        .busy      (busy),
        .done      (done),
        .reg_write (reg_write),
        .dir_WR    (dir_WR),
        .data_in   (data_in),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "simulation did not finish");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  dst;
        logic [31:0] exp_r;
        logic [2:0]  exp_f;   // {div0, ovf, zero}
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic from the operation definitions.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [2:0] f, output int lat);
        longint s;
        logic [63:0] p;
        logic ovf = 1'b0, div0 = 1'b0;
        lat = 1;
        r   = '0;
        case (o)
            3'd0: begin
                s = longint'($signed(a)) + longint'($signed(b));
                r = a + b;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                s = longint'($signed(a)) - longint'($signed(b));
                r = a - b;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: begin
                p = 64'(a) * 64'(b);
                r = p[31:0];
                ovf = (p[63:32] != 0);
                lat = 33;
            end
            3'd5, 3'd6: begin
                if (b == 0) begin
                    div0 = 1'b1;
                    r = (o == 3'd5) ? 32'hFFFF_FFFF : a;
                end else begin
                    r = (o == 3'd5) ? a / b : a % b;
                    lat = 33;
                end
            end
            default: r = '0;
        endcase
        f = {div0, ovf, (r == 0)};
    endfunction

    // Called at a negedge with the DUT idle; returns the write-back seen and its latency.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] d, output logic [31:0] r, output logic [2:0] f,
                          output logic [3:0] wr, output int lat);
        start = 1'b1; op = o; datA = a; datB = b; dir_dst = d;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        datA = $urandom; datB = $urandom; dir_dst = 4'($urandom);
        check("busy_after_accept", 64'(busy), 64'd1);
        lat = 1;
        while (!reg_write && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("done_with_write", 64'(done), 64'(reg_write));
        r = data_in; f = flags; wr = dir_WR;
        @(negedge clk);
        check("single_pulse", 64'(reg_write), 64'd0);
        check("idle_after_wb", 64'(busy), 64'd0);
    endtask

    vec_t vecs[14];

    initial begin
        logic [31:0] r, er;
        logic [2:0]  f, ef;
        logic [3:0]  wr;
        int          lat, elat, pulses;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic [3:0]  rd;

        vecs[0]  = '{3'd0, 32'h7FFF_FFFF, 32'd1,         4'd3,  32'h8000_0000, 3'b010, 1};
        vecs[1]  = '{3'd4, 32'h0001_0000, 32'h0001_0000, 4'd5,  32'h0000_0000, 3'b011, 33};
        vecs[2]  = '{3'd5, 32'd100,       32'd7,         4'd6,  32'd14,        3'b000, 33};
        vecs[3]  = '{3'd6, 32'd100,       32'd7,         4'd7,  32'd2,         3'b000, 33};
        vecs[4]  = '{3'd5, 32'd5,         32'd0,         4'd8,  32'hFFFF_FFFF, 3'b100, 1};
        vecs[5]  = '{3'd6, 32'd9,         32'd0,         4'd9,  32'd9,         3'b100, 1};
        vecs[6]  = '{3'd1, 32'h8000_0000, 32'd1,         4'd10, 32'h7FFF_FFFF, 3'b010, 1};
        vecs[7]  = '{3'd1, 32'd5,         32'd5,         4'd11, 32'd0,         3'b001, 1};
        vecs[8]  = '{3'd2, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'd12, 32'd0,         3'b001, 1};
        vecs[9]  = '{3'd3, 32'h1234_0000, 32'h0000_5678, 4'd13, 32'h1234_5678, 3'b000, 1};
        vecs[10] = '{3'd7, 32'hDEAD_BEEF, 32'h1234_5678, 4'd14, 32'd0,         3'b001, 1};
        vecs[11] = '{3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 32'd1,         3'b010, 33};
        vecs[12] = '{3'd5, 32'hFFFF_FFFF, 32'd1,         4'd1,  32'hFFFF_FFFF, 3'b000, 33};
        vecs[13] = '{3'd0, 32'hFFFF_FFFF, 32'd1,         4'd2,  32'd0,         3'b001, 1};

        // Power-on reset.
        rst = 1'b1; start = 1'b0; op = '0; dir_dst = '0; datA = '0; datB = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_reg_write", 64'(reg_write), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_outputs", {28'd0, dir_WR, data_in}, 64'd0);
        check("rst_flags", 64'(flags), 64'd0);

        // Reset in the middle of a MUL aborts it and clears the held write-back values.
        run_op(3'd0, 32'd5, 32'd6, 4'd9, r, f, wr, lat);
        check("pre_rst_add", 64'(r), 64'd11);
        start = 1'b1; op = 3'd4; datA = 32'd3; datB = 32'd4; dir_dst = 4'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        repeat (4) begin @(negedge clk); if (reg_write) pulses++; end
        rst = 1'b1;
        repeat (2) begin @(negedge clk); if (reg_write) pulses++; end
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_outputs", {28'd0, dir_WR, data_in}, 64'd0);
        check("midrst_flags", 64'(flags), 64'd0);
        repeat (40) begin @(negedge clk); if (reg_write || busy) pulses++; end
        check("midrst_no_writeback", 64'(pulses), 64'd0);

        // Directed vectors.
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dst, r, f, wr, lat);
            check($sformatf("vec%0d_data", i), 64'(r), 64'(vecs[i].exp_r));
            check($sformatf("vec%0d_flags", i), 64'(f), 64'(vecs[i].exp_f));
            check($sformatf("vec%0d_dir", i), 64'(wr), 64'(vecs[i].dst));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
        end

        // Hold start high during a DIVQ: ADD then SUB must be ignored until the
        // cycle after done, then SUB is accepted exactly once.
        start = 1'b1; op = 3'd5; datA = 32'd100; datB = 32'd7; dir_dst = 4'd6;
        @(posedge clk);
        @(negedge clk);
        op = 3'd0; datA = 32'd1; datB = 32'd2; dir_dst = 4'd1;
        pulses = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 20) begin op = 3'd1; datA = 32'd10; datB = 32'd3; dir_dst = 4'd2; end
            if (reg_write) begin
                pulses++;
                if (pulses == 1) begin
                    check("hold_div_cycle", 64'(n), 64'd33);
                    check("hold_div_data", 64'(data_in), 64'd14);
                end else if (pulses == 2) begin
                    check("hold_sub_cycle", 64'(n), 64'd35);
                    check("hold_sub_data", 64'(data_in), 64'd7);
                    check("hold_sub_dir", 64'(dir_WR), 64'd2);
                    start = 1'b0;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("hold_pulse_count", 64'(pulses), 64'd2);
        repeat (3) @(negedge clk);

        // Random ops against the model.
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            rd = 4'($urandom);
            model(ro, ra, rb, er, ef, elat);
            run_op(ro, ra, rb, rd, r, f, wr, lat);
            check($sformatf("rnd%0d_op%0d_data", i, ro), 64'(r), 64'(er));
            check($sformatf("rnd%0d_op%0d_flags", i, ro), 64'(f), 64'(ef));
            check($sformatf("rnd%0d_dir", i), 64'(wr), 64'(rd));
            check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(elat));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
